gray_cvt_arbiter: RTL and testbench

- Round-robin arbiter that shares one binary-to-Gray converter (i_en/i_data in, o_vld/o_gray out) among N_REQ requesters.
- Accepts requests, forwards one word per cycle to the converter, tags each issued word with the requester ID in an in-order tag FIFO, and routes each converter result back with its ID.
- Sits between the requesting datapaths and the single converter instance.

---
 rtl/gray_cvt_arbiter.sv | 125 ++++++++++++
 tb/tb_gray_cvt_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_cvt_arbiter.sv
// rtl/gray_cvt_arbiter.sv - round-robin arbiter sharing one binary-to-Gray converter
module gray_cvt_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DW      = 8,
  parameter int MAX_OUT = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [N_REQ-1:0]         i_req,
  input  logic [N_REQ*DW-1:0]      i_data,
  output logic [N_REQ-1:0]         o_gnt,
  output logic                     o_cvt_en,
  output logic [DW-1:0]            o_cvt_data,
  input  logic                     i_cvt_vld,
  input  logic [DW-1:0]            i_cvt_gray,
  output logic                     o_rsp_vld,
  output logic [$clog2(N_REQ)-1:0] o_rsp_id,
  output logic [DW-1:0]            o_rsp_gray,
  output logic                     o_busy,
  output logic                     o_err
);

  localparam int IDW = $clog2(N_REQ);
  localparam int AW  = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CW  = $clog2(MAX_OUT + 1);

  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] r_tag [MAX_OUT];
  logic [AW-1:0]  r_wr;
  logic [AW-1:0]  r_rd;
  logic [CW-1:0]  r_count;
  logic           r_cvt_en;
  logic [DW-1:0]  r_cvt_data;
  logic           r_rsp_vld;
  logic [IDW-1:0] r_rsp_id;
  logic [DW-1:0]  r_rsp_gray;
  logic           r_err;

  logic           w_gnt_any;
  logic [IDW-1:0] w_gnt_idx;
  logic [IDW-1:0] w_cand;
  logic [IDW-1:0] w_ptr_nxt;
  logic [AW-1:0]  w_wr_nxt;
  logic [AW-1:0]  w_rd_nxt;
  logic [DW-1:0]  w_sel_data;
  logic           w_push;
  logic           w_pop;
  logic           w_spur;

  // Full gate looks only at the registered count; a same-cycle pop does not free a slot.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    if (!i_rst && (r_count < CW'(MAX_OUT))) begin
      for (int i = 0; i < N_REQ; i++) begin
        w_cand = IDW'((int'(r_ptr) + i) % N_REQ);
        if (!w_gnt_any && i_req[w_cand]) begin
          w_gnt_any = 1'b1;
          w_gnt_idx = w_cand;
        end
      end
    end
  end

  assign o_gnt      = w_gnt_any ? (N_REQ'(1) << w_gnt_idx) : '0;
  assign w_sel_data = i_data[w_gnt_idx*DW +: DW];
  assign w_push     = w_gnt_any;
  assign w_pop      = i_cvt_vld && (r_count != '0);
  assign w_spur     = i_cvt_vld && (r_count == '0);
  assign w_ptr_nxt  = (w_gnt_idx == IDW'(N_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
  assign w_wr_nxt   = (r_wr == AW'(MAX_OUT - 1)) ? '0 : r_wr + 1'b1;
  assign w_rd_nxt   = (r_rd == AW'(MAX_OUT - 1)) ? '0 : r_rd + 1'b1;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_tag[r_wr] <= w_gnt_idx;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr      <= '0;
      r_wr       <= '0;
      r_rd       <= '0;
      r_count    <= '0;
      r_cvt_en   <= 1'b0;
      r_cvt_data <= '0;
      r_rsp_vld  <= 1'b0;
      r_rsp_id   <= '0;
      r_rsp_gray <= '0;
      r_err      <= 1'b0;
    end else begin
      r_cvt_en  <= w_push;
      r_rsp_vld <= w_pop;
      if (w_push) begin
        r_ptr      <= w_ptr_nxt;
        r_wr       <= w_wr_nxt;
        r_cvt_data <= w_sel_data;
      end
      if (w_pop) begin
        r_rd       <= w_rd_nxt;
        r_rsp_id   <= r_tag[r_rd];
        r_rsp_gray <= i_cvt_gray;
      end
      if (w_spur) begin
        r_err <= 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_cvt_en   = r_cvt_en;
  assign o_cvt_data = r_cvt_data;
  assign o_rsp_vld  = r_rsp_vld;
  assign o_rsp_id   = r_rsp_id;
  assign o_rsp_gray = r_rsp_gray;
  assign o_busy     = (r_count != '0);
  assign o_err      = r_err;

endmodule

// File: tb/tb_gray_cvt_arbiter.sv
// tb/tb_gray_cvt_arbiter.sv - randomized self-checking bench for gray_cvt_arbiter
module tb_gray_cvt_arbiter;

  localparam int N  = 4;
  localparam int MO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] data = '0;
  logic [3:0]  gnt;
  logic        cvt_en;
  logic [7:0]  cvt_data;
  logic        cvt_vld;
  logic [7:0]  cvt_gray;
  logic        rsp_vld;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_gray;
  logic        busy;
  logic        err;

  int n_cmp  = 0;
  int n_fail = 0;
  int lat    = 1;
  logic spur   = 1'b0;
  logic mon_en = 1'b0;

  gray_cvt_arbiter #(.N_REQ(N), .DW(8), .MAX_OUT(MO)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_data(data), .o_gnt(gnt),
    .o_cvt_en(cvt_en), .o_cvt_data(cvt_data), .i_cvt_vld(cvt_vld), .i_cvt_gray(cvt_gray),
    .o_rsp_vld(rsp_vld), .o_rsp_id(rsp_id), .o_rsp_gray(rsp_gray), .o_busy(busy), .o_err(err)
  );

  always #5 clk = ~clk;

  // Fixed-latency converter stand-in; not reset by the arbiter's reset.
  logic [15:0] pipe_v = '0;
  logic [7:0]  pipe_g [16];
  always @(posedge clk) begin
    pipe_v    <= {pipe_v[14:0], cvt_en};
    pipe_g[0] <= cvt_data ^ (cvt_data >> 1);
    for (int i = 1; i < 16; i++) pipe_g[i] <= pipe_g[i-1];
  end
  assign cvt_vld  = pipe_v[lat-1] | spur;
  assign cvt_gray = spur ? 8'h00 : pipe_g[lat-1];

  int         m_ptr = 0;
  int         m_id_q[$];
  logic [7:0] m_d_q[$];
  logic       m_cvt_en = 1'b0;
  logic [7:0] m_cvt_data = '0;
  logic       m_rsp_vld = 1'b0;
  int         m_rsp_id = 0;
  logic [7:0] m_rsp_gray = '0;
  logic       m_err = 1'b0;

  function automatic int f_pick();
    if (rst || m_id_q.size() >= MO) return -1;
    for (int i = 0; i < N; i++) begin
      if (req[(m_ptr + i) % N]) return (m_ptr + i) % N;
    end
    return -1;
  endfunction

  function automatic logic [3:0] f_gnt();
    int k;
    k = f_pick();
    return (k < 0) ? 4'b0000 : 4'(1 << k);
  endfunction

  task automatic model_step();
    int g;
    logic [7:0] d;
    if (rst) begin
      m_ptr = 0; m_id_q.delete(); m_d_q.delete();
      m_cvt_en = 0; m_cvt_data = 0; m_rsp_vld = 0; m_rsp_id = 0; m_rsp_gray = 0; m_err = 0;
    end else begin
      g = f_pick();
      m_rsp_vld = 0;
      if (cvt_vld) begin
        if (m_id_q.size() > 0) begin
          m_rsp_vld  = 1;
          m_rsp_id   = m_id_q.pop_front();
          d          = m_d_q.pop_front();
          m_rsp_gray = d ^ (d >> 1);
        end else begin
          m_err = 1;
        end
      end
      m_cvt_en = (g >= 0);
      if (g >= 0) begin
        m_ptr = (g + 1) % N;
        m_id_q.push_back(g);
        m_d_q.push_back(data[g*8 +: 8]);
        m_cvt_data = data[g*8 +: 8];
      end
    end
  endtask

  always @(posedge clk or posedge rst) model_step();

  task automatic monitor_check();
    logic [3:0] eg;
    eg = f_gnt();
    n_cmp++; if (gnt !== eg) begin n_fail++; $display("FAIL mon_gnt t=%0t got=%b exp=%b", $time, gnt, eg); end
    n_cmp++; if (cvt_en !== m_cvt_en) begin n_fail++; $display("FAIL mon_cvt_en t=%0t got=%b exp=%b", $time, cvt_en, m_cvt_en); end
    n_cmp++; if (cvt_data !== m_cvt_data) begin n_fail++; $display("FAIL mon_cvt_data t=%0t got=%h exp=%h", $time, cvt_data, m_cvt_data); end
    n_cmp++; if (rsp_vld !== m_rsp_vld) begin n_fail++; $display("FAIL mon_rsp_vld t=%0t got=%b exp=%b", $time, rsp_vld, m_rsp_vld); end
    if (m_rsp_vld) begin
      n_cmp++; if (rsp_id !== 2'(m_rsp_id)) begin n_fail++; $display("FAIL mon_rsp_id t=%0t got=%0d exp=%0d", $time, rsp_id, m_rsp_id); end
      n_cmp++; if (rsp_gray !== m_rsp_gray) begin n_fail++; $display("FAIL mon_rsp_gray t=%0t got=%h exp=%h", $time, rsp_gray, m_rsp_gray); end
    end
    n_cmp++; if (busy !== (m_id_q.size() > 0)) begin n_fail++; $display("FAIL mon_busy t=%0t got=%b exp=%b", $time, busy, m_id_q.size() > 0); end
    n_cmp++; if (err !== m_err) begin n_fail++; $display("FAIL mon_err t=%0t got=%b exp=%b", $time, err, m_err); end
  endtask

  always @(negedge clk) if (mon_en) monitor_check();

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int t;
    req = '0;
    t = 0;
    while (busy !== 1'b0 && t < 200) begin cyc(); t++; end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL drain_timeout busy=%b exp=0", busy); end
    repeat (18) cyc();
  endtask

  task automatic test_reset();
    req = 4'hF; data = $urandom;
    repeat (3) cyc();
    n_cmp++; if ({gnt, cvt_en, cvt_data, rsp_vld} !== 14'd0) begin n_fail++; $display("FAIL reset_fwd got=%h exp=0", {gnt, cvt_en, cvt_data, rsp_vld}); end
    n_cmp++; if ({rsp_id, rsp_gray, busy, err} !== 12'd0) begin n_fail++; $display("FAIL reset_rsp got=%h exp=0", {rsp_id, rsp_gray, busy, err}); end
    rst = 1'b0; req = '0;
    mon_en = 1'b1;
    repeat (2) cyc();
  endtask

  task automatic test_single();
    lat = 1;
    data[23:16] = 8'h05; req = 4'b0100;
    #1;
    n_cmp++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL single_gnt got=%b exp=0100", gnt); end
    cyc(); req = '0;
    n_cmp++; if (cvt_en !== 1'b1 || cvt_data !== 8'h05) begin n_fail++; $display("FAIL single_cvt got=%b/%h exp=1/05", cvt_en, cvt_data); end
    cyc();
    n_cmp++; if (rsp_vld !== 1'b0) begin n_fail++; $display("FAIL single_early got=%b exp=0", rsp_vld); end
    cyc();
    n_cmp++; if (rsp_vld !== 1'b1 || rsp_id !== 2'd2 || rsp_gray !== 8'h07) begin
      n_fail++; $display("FAIL single_rsp got=%b/%0d/%h exp=1/2/07", rsp_vld, rsp_id, rsp_gray);
    end
    drain();
  endtask

  task automatic test_fairness();
    int cnt [N];
    for (int k = 0; k < N; k++) cnt[k] = 0;
    lat = 1;
    rst = 1'b1; cyc(); cyc(); rst = 1'b0;
    for (int n = 0; n < 256; n++) begin
      req = 4'hF; data = $urandom;
      #1;
      n_cmp++; if (gnt !== 4'(1 << (n % N))) begin n_fail++; $display("FAIL fair_seq n=%0d got=%b exp=%b", n, gnt, 4'(1 << (n % N))); end
      for (int k = 0; k < N; k++) if (gnt[k]) cnt[k]++;
      cyc();
    end
    for (int k = 0; k < N; k++) begin
      n_cmp++; if (cnt[k] != 64) begin n_fail++; $display("FAIL fair_count req=%0d got=%0d exp=64", k, cnt[k]); end
    end
    drain();
  endtask

  task automatic test_sweep();
    int sent, got, en_n;
    logic started, ended;
    logic [7:0] gv, last;
    sent = 0; got = 0; en_n = 0; started = 0; ended = 0; last = '0;
    lat = 1;
    for (int c = 0; c < 300; c++) begin
      data[15:8] = 8'(sent);
      req = (sent < 256) ? 4'b0010 : 4'b0000;
      #1;
      if (req[1]) begin
        n_cmp++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL sweep_gnt c=%0d got=%b exp=0010", c, gnt); end
        else sent++;
      end
      if (rsp_vld) begin
        gv = 8'(got);
        n_cmp++; if (rsp_id !== 2'd1 || rsp_gray !== (gv ^ (gv >> 1))) begin
          n_fail++; $display("FAIL sweep_rsp i=%0d got=%0d/%h exp=1/%h", got, rsp_id, rsp_gray, gv ^ (gv >> 1));
        end
        last = rsp_gray; got++;
      end
      if (cvt_en) begin
        n_cmp++; if (ended) begin n_fail++; $display("FAIL sweep_en_gap c=%0d got=1 after gap exp=continuous", c); end
        started = 1; en_n++;
      end else if (started) ended = 1;
      cyc();
    end
    n_cmp++; if (got != 256 || en_n != 256) begin n_fail++; $display("FAIL sweep_count got=%0d/%0d exp=256/256", got, en_n); end
    n_cmp++; if (last !== 8'h80) begin n_fail++; $display("FAIL sweep_last got=%h exp=80", last); end
    drain();
  endtask

  task automatic test_backpressure();
    int n_g, n_v, level;
    logic seen;
    n_g = 0; n_v = 0; seen = 0;
    lat = 10;
    for (int c = 0; c < 80; c++) begin
      req = 4'hF; data = $urandom;
      #1;
      level = n_g - n_v;
      n_cmp++; if (level > MO || (level == MO && gnt !== 4'b0000)) begin
        n_fail++; $display("FAIL bp_full c=%0d outstanding=%0d gnt=%b exp<=4 and no grant when full", c, level, gnt);
      end
      if (cvt_vld && !seen) begin
        seen = 1;
        n_cmp++; if (n_g != 4) begin n_fail++; $display("FAIL bp_first got=%0d grants exp=4", n_g); end
      end
      if (gnt != 0) n_g++;
      if (cvt_vld && level > 0) n_v++;
      cyc();
    end
    n_cmp++; if (!seen) begin n_fail++; $display("FAIL bp_no_vld got=0 exp=1"); end
    drain();
    lat = 1;
  endtask

  task automatic test_error();
    spur = 1'b1;
    cyc(); spur = 1'b0;
    n_cmp++; if (err !== 1'b1 || rsp_vld !== 1'b0) begin n_fail++; $display("FAIL err_set got=%b/%b exp=1/0", err, rsp_vld); end
    repeat (5) cyc();
    req = 4'b0001; data = $urandom; cyc(); req = '0;
    repeat (4) cyc();
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky got=%b exp=1", err); end
    drain();
    rst = 1'b1; #1;
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_clear got=%b exp=0", err); end
    cyc(); rst = 1'b0;
    cyc();
  endtask

  task automatic test_reset_mid();
    lat = 3;
    repeat (20) begin req = 4'($urandom); data = $urandom; cyc(); end
    req = 4'hF;
    rst = 1'b1; #1;
    n_cmp++; if ({gnt, cvt_en, cvt_data, rsp_vld, rsp_id, rsp_gray, busy, err} !== 26'd0) begin
      n_fail++; $display("FAIL rstmid_outs got=%h exp=0", {gnt, cvt_en, cvt_data, rsp_vld, rsp_id, rsp_gray, busy, err});
    end
    repeat (5) cyc();
    rst = 1'b0; req = 4'b1001;
    #1;
    n_cmp++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL rstmid_first got=%b exp=0001", gnt); end
    cyc(); req = 4'b1000;
    #1;
    n_cmp++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL rstmid_second got=%b exp=1000", gnt); end
    cyc();
    drain();
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL rstmid_err got=%b exp=0", err); end
  endtask

  task automatic test_random();
    int lats [3] = '{1, 2, 5};
    for (int j = 0; j < 3; j++) begin
      lat = lats[j];
      repeat (300) begin req = 4'($urandom); data = $urandom; cyc(); end
      drain();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_sweep();
    test_backpressure();
    test_error();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog run did not complete exp=finish");
    $fatal(1);
  end

endmodule
